mc_luma_ctrl: RTL and testbench
===============================

// Module: mc_luma_ctrl
// PURPOSE
//  Sequences one luma MC partition through mc_luma. Latches MV fraction and size at start, splits
//  the block into 8-pel-wide strips (ip0 = cols 0-3, ip1 = cols 4-7), and issues H+5 reference-row
//  reads per strip. Drives rpvalid/area_co_locate/end_oneblk, then counts mc_luma_wren rows into
//  MC-buffer write addresses and pulses done. Sits between fme/mc top control and mc_luma.
// PARAMETERS
//  RADDR_W  7  reference-window row address width
//  CADDR_W  7  reference-window column (pel) address width
//  WADDR_W  5  MC buffer row address width (max 2 strips x 16 rows)
// PORTS
//  clk_i             in   1        clock
//  rst_i             in   1        synchronous reset, active high
//  start_i           in   1        start one partition; ignored unless IDLE
//  blk_w_i           in   1        0: width 8 (1 strip), 1: width 16 (2 strips)
//  blk_h_i           in   2        0: H=4, 1: H=8, 2: H=16, 3: reserved (treated as 16)
//  mv_frac_i         in   4        {y_frac[1:0], x_frac[1:0]} quarter-pel fraction
//  ref_y_i           in   RADDR_W  window row of block top minus 2
//  ref_x_i           in   CADDR_W  window column of block left minus 2
//  ref_rd_en_o       out  1        reference read strobe; data valid exactly 1 cycle later
//  ref_rd_row_o      out  RADDR_W  ref_y + row index
//  ref_rd_col_o      out  CADDR_W  ref_x + 8*strip
//  rpvalid_o         out  1        to ip0_rpvalid_i and ip1_rpvalid_i
//  area_co_locate_o  out  1        to area_co_locate_i
//  end_oneblk_input_o out 1        to end_oneblk_input_i
//  end_oneblk_ip_i   in   1        from end_oneblk_ip_o: strip flushed
//  hfrac_o           out  4        to HFracl0_i and HFracl1_i
//  qfrac_o           out  4        to QFracl0_i and QFracl1_i
//  half_ip_flag_o    out  1        constant 0 (quarter refinement)
//  mc_luma_wren_i    in   1        from mc_luma_wren_o: one 8-pel output row valid
//  mc_wr_en_o        out  1        MC buffer write enable (= mc_luma_wren_i while BUSY)
//  mc_wr_addr_o      out  WADDR_W  strip*H + output row
//  busy_o            out  1        high from accepted start to done
//  done_o            out  1        1-cycle pulse after last row written
// BEHAVIOUR
//  Reset: state IDLE, counters 0, every output 0.
//  FSM IDLE -> FEED (start_i) -> FLUSH (last row issued) -> FEED (end_oneblk_ip_i, strips remain)
//     | DRAIN (end_oneblk_ip_i, last strip) -> IDLE (row count = strips*H, with done_o pulse).
//  start accept: latch blk_w, blk_h, mv_frac, ref_y, ref_x; busy_o=1 next cycle.
//  FEED: ref_rd_en_o=1 every cycle, row r = 0..H+4; no back-pressure. rpvalid_o = rd_en delayed 1.
//  area_co_locate_o = (r>=5) delayed 1; end_oneblk_input_o = (r==H+4) delayed 1 (aligned with data).
//  FLUSH: no reads; wait for end_oneblk_ip_i; next strip starts cycle after it.
//  hfrac_o = {y_frac[1],1'b0... } encoded as {y_frac[1],y_frac[1],x_frac[1],x_frac[1]} half-pel grid;
//  qfrac_o = mv_frac latched; both stable for whole BUSY period.
//  Output rows: write counter increments on mc_luma_wren_i only while busy; mc_wr_addr_o = counter.
//  Wren outside BUSY: mc_wr_en_o=0, counter unchanged. Counter reaching strips*H forces DRAIN exit.
//  end_oneblk_ip_i in FEED or IDLE: ignored. start_i while busy: ignored (no latch).
//  done_o and a new start_i same cycle: start accepted (IDLE reached on done cycle).
//  rst_i mid-operation: IDLE next cycle, all outputs 0, partial writes abandoned.
//  Widths: row counter 5 bits (max 20), col add ref_x+8 wraps mod 2^CADDR_W (caller guarantees range).
// STRUCTURE
//  Shared package mc_defines: BLK_H_4/8/16 codes, FSM state enum, H-decode function.
//  One sub-module natural: mc_luma_ctrl_dly (3-bit x 1-cycle align: rpvalid, area, end).
//  Remaining FSM + read/write counters in this module; no datapath.
// TESTING
//  8x4, mv_frac=0: start -> 9 reads rows ref_y..+8, area high on rpvalid cycles 6-9, end on 9th; after
//   4 wrens, addr 0..3, done_o 1 cycle later, busy_o low.
//  16x16, mv_frac=4'b0101: 21 reads col ref_x, FLUSH, 21 reads col ref_x+8; addr 0..31; hfrac/qfrac stable.
//  start_i asserted during FEED with different size -> ignored; row/strip counts unchanged.
//  rst_i in FEED after 3 reads -> next cycle all outputs 0, state IDLE; fresh start behaves normally.
//  mc_luma_wren_i pulsed while IDLE -> mc_wr_en_o=0, later block addresses start at 0.
//  done_o with start_i same cycle -> second block's first read 1 cycle after done.

Source files
------------

// File: rtl/mc_luma_ctrl_pkg.sv
// Shared definitions for the luma MC partition sequencer: block-height codes,
// FSM state encoding and the height decode helper.
package mc_luma_ctrl_pkg;

    localparam logic [1:0] BLK_H_4  = 2'd0;
    localparam logic [1:0] BLK_H_8  = 2'd1;
    localparam logic [1:0] BLK_H_16 = 2'd2;

    localparam int ROW_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Code 3 is reserved and behaves like a 16-row block.
    function automatic logic [ROW_W-1:0] h_decode(input logic [1:0] code);
        case (code)
            BLK_H_4:  return 5'd4;
            BLK_H_8:  return 5'd8;
            BLK_H_16: return 5'd16;
            default:  return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/mc_luma_ctrl_dly.sv
// One-cycle alignment of per-read flags so they line up with the reference
// data, which arrives one cycle after the read strobe.
module mc_luma_ctrl_dly #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_dly
            logic bit_reg;
            always_ff @(posedge clk) begin
                if (srst) begin
                    bit_reg <= 1'b0;
                end else begin
                    bit_reg <= din[gi];
                end
            end
            assign dout[gi] = bit_reg;
        end
    endgenerate

endmodule

// File: rtl/mc_luma_ctrl.sv
// Sequences one luma MC partition: reference-row reads per 8-pel strip,
// interpolator side-band strobes, and MC-buffer write addressing.
module mc_luma_ctrl
    import mc_luma_ctrl_pkg::*;
#(
    parameter int RADDR_W = 7,
    parameter int CADDR_W = 7,
    parameter int WADDR_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               blk_w_i,
    input  logic [1:0]         blk_h_i,
    input  logic [3:0]         mv_frac_i,
    input  logic [RADDR_W-1:0] ref_y_i,
    input  logic [CADDR_W-1:0] ref_x_i,
    output logic               ref_rd_en_o,
    output logic [RADDR_W-1:0] ref_rd_row_o,
    output logic [CADDR_W-1:0] ref_rd_col_o,
    output logic               rpvalid_o,
    output logic               area_co_locate_o,
    output logic               end_oneblk_input_o,
    input  logic               end_oneblk_ip_i,
    output logic [3:0]         hfrac_o,
    output logic [3:0]         qfrac_o,
    output logic               half_ip_flag_o,
    input  logic               mc_luma_wren_i,
    output logic               mc_wr_en_o,
    output logic [WADDR_W-1:0] mc_wr_addr_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int CNT_W = WADDR_W + 1;

    state_t             state_reg;
    logic [ROW_W-1:0]   row_reg;
    logic [ROW_W-1:0]   h_reg;
    logic               strip_reg;
    logic               blk_w_reg;
    logic [RADDR_W-1:0] ref_y_reg;
    logic [CADDR_W-1:0] ref_x_reg;
    logic               rd_en_reg;
    logic [RADDR_W-1:0] rd_row_reg;
    logic [CADDR_W-1:0] rd_col_reg;
    logic               area_reg;
    logic               end_reg;
    logic [3:0]         hfrac_reg;
    logic [3:0]         qfrac_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [CNT_W-1:0]   wr_cnt_reg;

    logic [CNT_W-1:0]   wr_cnt_next;
    logic [CNT_W-1:0]   total_rows;
    logic [ROW_W-1:0]   last_row;
    logic               wr_fire;

    assign wr_fire     = busy_reg & mc_luma_wren_i;
    assign wr_cnt_next = wr_cnt_reg + CNT_W'(wr_fire);
    assign total_rows  = blk_w_reg ? CNT_W'({h_reg, 1'b0}) : CNT_W'({1'b0, h_reg});
    // Six-tap filter needs H+5 source rows per strip: rows 0..H+4.
    assign last_row    = h_reg + 5'd4;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            row_reg    <= '0;
            h_reg      <= '0;
            strip_reg  <= 1'b0;
            blk_w_reg  <= 1'b0;
            ref_y_reg  <= '0;
            ref_x_reg  <= '0;
            rd_en_reg  <= 1'b0;
            rd_row_reg <= '0;
            rd_col_reg <= '0;
            area_reg   <= 1'b0;
            end_reg    <= 1'b0;
            hfrac_reg  <= '0;
            qfrac_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            wr_cnt_reg <= '0;
        end else begin
            done_reg   <= 1'b0;
            wr_cnt_reg <= wr_cnt_next;
            case (state_reg)
                ST_IDLE: begin
                    if (start_i) begin
                        blk_w_reg  <= blk_w_i;
                        h_reg      <= h_decode(blk_h_i);
                        ref_y_reg  <= ref_y_i;
                        ref_x_reg  <= ref_x_i;
                        hfrac_reg  <= {mv_frac_i[3], mv_frac_i[3], mv_frac_i[1], mv_frac_i[1]};
                        qfrac_reg  <= mv_frac_i;
                        strip_reg  <= 1'b0;
                        row_reg    <= '0;
                        wr_cnt_reg <= '0;
                        busy_reg   <= 1'b1;
                        rd_en_reg  <= 1'b1;
                        rd_row_reg <= ref_y_i;
                        rd_col_reg <= ref_x_i;
                        area_reg   <= 1'b0;
                        end_reg    <= 1'b0;
                        state_reg  <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (row_reg == last_row) begin
                        rd_en_reg <= 1'b0;
                        area_reg  <= 1'b0;
                        end_reg   <= 1'b0;
                        state_reg <= ST_FLUSH;
                    end else begin
                        row_reg    <= row_reg + 5'd1;
                        rd_row_reg <= ref_y_reg + RADDR_W'(row_reg + 5'd1);
                        area_reg   <= (row_reg >= 5'd4);
                        end_reg    <= ((row_reg + 5'd1) == last_row);
                    end
                end
                ST_FLUSH: begin
                    if (end_oneblk_ip_i) begin
                        if (blk_w_reg && !strip_reg) begin
                            strip_reg  <= 1'b1;
                            row_reg    <= '0;
                            rd_en_reg  <= 1'b1;
                            rd_row_reg <= ref_y_reg;
                            rd_col_reg <= ref_x_reg + CADDR_W'(8);
                            area_reg   <= 1'b0;
                            end_reg    <= 1'b0;
                            state_reg  <= ST_FEED;
                        end else begin
                            state_reg  <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Rows may already be complete when DRAIN is entered.
                    if (wr_cnt_next == total_rows) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    mc_luma_ctrl_dly #(
        .W(3)
    ) u_dly (
        .clk  (clk_i),
        .srst (rst_i),
        .din  ({end_reg, area_reg, rd_en_reg}),
        .dout ({end_oneblk_input_o, area_co_locate_o, rpvalid_o})
    );

    assign ref_rd_en_o    = rd_en_reg;
    assign ref_rd_row_o   = rd_row_reg;
    assign ref_rd_col_o   = rd_col_reg;
    assign hfrac_o        = hfrac_reg;
    assign qfrac_o        = qfrac_reg;
    assign half_ip_flag_o = 1'b0;
    assign mc_wr_en_o     = wr_fire;
    assign mc_wr_addr_o   = wr_cnt_reg[WADDR_W-1:0];
    assign busy_o         = busy_reg;
    assign done_o         = done_reg;

endmodule

// File: tb/tb_mc_luma_ctrl.sv
// Directed and randomized partitions against a behavioural model of the
// read/strobe/write sequence, acting as a simple mc_luma stand-in.
module tb_mc_luma_ctrl;

    logic       clk = 1'b0;
    logic       rst_i, start_i, blk_w_i, end_oneblk_ip_i, mc_luma_wren_i;
    logic [1:0] blk_h_i;
    logic [3:0] mv_frac_i;
    logic [6:0] ref_y_i, ref_x_i;
    logic       ref_rd_en_o, rpvalid_o, area_co_locate_o, end_oneblk_input_o;
    logic [6:0] ref_rd_row_o, ref_rd_col_o;
    logic [3:0] hfrac_o, qfrac_o;
    logic       half_ip_flag_o, mc_wr_en_o, busy_o, done_o;
    logic [4:0] mc_wr_addr_o;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int check_cnt = 0;
    bit started   = 1'b0;

    typedef struct packed {
        logic       w;
        logic [1:0] hc;
        logic [3:0] mv;
        logic [6:0] y;
        logic [6:0] x;
    } blk_t;

    always #5 clk = ~clk;

    mc_luma_ctrl #(.RADDR_W(7), .CADDR_W(7), .WADDR_W(5)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .start_i            (start_i),
        .blk_w_i            (blk_w_i),
        .blk_h_i            (blk_h_i),
        .mv_frac_i          (mv_frac_i),
        .ref_y_i            (ref_y_i),
        .ref_x_i            (ref_x_i),
        .ref_rd_en_o        (ref_rd_en_o),
        .ref_rd_row_o       (ref_rd_row_o),
        .ref_rd_col_o       (ref_rd_col_o),
        .rpvalid_o          (rpvalid_o),
        .area_co_locate_o   (area_co_locate_o),
        .end_oneblk_input_o (end_oneblk_input_o),
        .end_oneblk_ip_i    (end_oneblk_ip_i),
        .hfrac_o            (hfrac_o),
        .qfrac_o            (qfrac_o),
        .half_ip_flag_o     (half_ip_flag_o),
        .mc_luma_wren_i     (mc_luma_wren_i),
        .mc_wr_en_o         (mc_wr_en_o),
        .mc_wr_addr_o       (mc_wr_addr_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic blk_t mk(input logic w, input logic [1:0] hc, input logic [3:0] mv,
                                input logic [6:0] y, input logic [6:0] x);
        blk_t b;
        b.w = w; b.hc = hc; b.mv = mv; b.y = y; b.x = x;
        return b;
    endfunction

    function automatic blk_t rnd_blk();
        return mk(1'($urandom), 2'($urandom), 4'($urandom), 7'($urandom), 7'($urandom));
    endfunction

    function automatic int rows_of(input logic [1:0] hc);
        if (hc == 2'd0) return 4;
        if (hc == 2'd1) return 8;
        return 16;
    endfunction

    function automatic logic [3:0] half_grid(input logic [3:0] mv);
        return {mv[3], mv[3], mv[1], mv[1]};
    endfunction

    task automatic drive_start(input blk_t b);
        start_i   = 1'b1;
        blk_w_i   = b.w;
        blk_h_i   = b.hc;
        mv_frac_i = b.mv;
        ref_y_i   = b.y;
        ref_x_i   = b.x;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, ref_rd_en_o, 0);
        check({tag, "_row"}, ref_rd_row_o, 0);
        check({tag, "_col"}, ref_rd_col_o, 0);
        check({tag, "_rpvalid"}, rpvalid_o, 0);
        check({tag, "_area"}, area_co_locate_o, 0);
        check({tag, "_end"}, end_oneblk_input_o, 0);
        check({tag, "_hfrac"}, hfrac_o, 0);
        check({tag, "_qfrac"}, qfrac_o, 0);
        check({tag, "_half"}, half_ip_flag_o, 0);
        check({tag, "_wr_en"}, mc_wr_en_o, 0);
        check({tag, "_wr_addr"}, mc_wr_addr_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
    endtask

    // One output row from the interpolator, after a random idle gap.
    task automatic do_wren(input int addr);
        repeat ($urandom_range(0, 2)) begin
            check("gap_rd_en", ref_rd_en_o, 0);
            step();
        end
        mc_luma_wren_i = 1'b1;
        #1;
        check("wr_en", mc_wr_en_o, 1);
        check("wr_addr", mc_wr_addr_o, addr);
        step();
        mc_luma_wren_i = 1'b0;
    endtask

    // Runs one partition; with chain set, the next block is started on the done cycle.
    task automatic run_block(input blk_t b, input bit chain, input blk_t nb);
        int h, ns, kpre, wa;
        h    = rows_of(b.hc);
        ns   = b.w ? 2 : 1;
        kpre = $urandom_range(0, h - 1);
        wa   = 0;
        if (!started) begin
            drive_start(b);
            step();
            start_i = 1'b0;
        end
        started = 1'b0;
        check("busy_start", busy_o, 1);
        check("done_start", done_o, 0);
        for (int s = 0; s < ns; s++) begin
            for (int k = 0; k <= h + 5; k++) begin
                check("rd_en", ref_rd_en_o, (k <= h + 4) ? 1 : 0);
                if (k <= h + 4) begin
                    check("rd_row", ref_rd_row_o, (b.y + k) % 128);
                    check("rd_col", ref_rd_col_o, (b.x + 8 * s) % 128);
                end
                check("rpvalid", rpvalid_o, (k >= 1) ? 1 : 0);
                check("area", area_co_locate_o, (k - 1 >= 5) ? 1 : 0);
                check("end_in", end_oneblk_input_o, (k - 1 == h + 4) ? 1 : 0);
                check("hfrac", hfrac_o, half_grid(b.mv));
                check("qfrac", qfrac_o, b.mv);
                check("busy", busy_o, 1);
                if (k <= h + 4) begin
                    // Stray end pulses and restarts while reading must be ignored.
                    end_oneblk_ip_i = ($urandom_range(0, 5) == 0);
                    start_i   = ($urandom_range(0, 5) == 0);
                    blk_w_i   = 1'($urandom);
                    blk_h_i   = 2'($urandom);
                    mv_frac_i = 4'($urandom);
                    ref_y_i   = 7'($urandom);
                    ref_x_i   = 7'($urandom);
                    step();
                end
            end
            end_oneblk_ip_i = 1'b0;
            start_i         = 1'b0;
            for (int i = 0; i < ((s == ns - 1) ? kpre : h); i++) begin
                do_wren(wa);
                wa++;
            end
            end_oneblk_ip_i = 1'b1;
            step();
            end_oneblk_ip_i = 1'b0;
        end
        for (int i = kpre; i < h; i++) begin
            check("drain_busy", busy_o, 1);
            do_wren(wa);
            wa++;
        end
        check("done_pulse", done_o, 1);
        check("done_busy", busy_o, 0);
        check("done_rd_en", ref_rd_en_o, 0);
        $display("block w=%0d h=%0d mv=%h y=%0d x=%0d rows=%0d chain=%0d", 8 * ns, h, b.mv, b.y, b.x, wa, chain);
        if (chain) begin
            drive_start(nb);
            started = 1'b1;
            step();
            start_i = 1'b0;
        end else begin
            step();
            check("done_clear", done_o, 0);
            check("idle_busy", busy_o, 0);
        end
    endtask

    initial begin
        blk_t b1, b2;
        rst_i = 1'b1; start_i = 1'b0; blk_w_i = 1'b0; blk_h_i = 2'd0; mv_frac_i = 4'd0;
        ref_y_i = 7'd0; ref_x_i = 7'd0; end_oneblk_ip_i = 1'b0; mc_luma_wren_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        check_all_zero("reset");

        run_block(mk(1'b0, 2'd0, 4'b0000, 7'd10, 7'd20), 1'b0, '0);
        run_block(mk(1'b1, 2'd2, 4'b0101, 7'd30, 7'd124), 1'b0, '0);
        run_block(mk(1'b1, 2'd3, 4'b1010, 7'd120, 7'd5), 1'b0, '0);

        // Interpolator rows while idle must neither write nor advance the address.
        mc_luma_wren_i = 1'b1;
        #1;
        check("idle_wr_en", mc_wr_en_o, 0);
        step();
        step();
        check("idle_wr_addr", mc_wr_addr_o, 0);
        mc_luma_wren_i = 1'b0;
        run_block(mk(1'b0, 2'd1, 4'b1111, 7'd3, 7'd9), 1'b0, '0);

        // Reset after three reads of a block.
        drive_start(mk(1'b1, 2'd2, 4'b1001, 7'd50, 7'd60));
        step();
        start_i = 1'b0;
        step();
        step();
        check("pre_rst_row", ref_rd_row_o, 52);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check_all_zero("mid_rst");
        run_block(mk(1'b1, 2'd0, 4'b0110, 7'd77, 7'd33), 1'b0, '0);

        // Back-to-back blocks: new start accepted on the done cycle.
        b1 = rnd_blk();
        b2 = rnd_blk();
        run_block(b1, 1'b1, b2);
        run_block(b2, 1'b0, '0);

        for (int n = 0; n < 6; n++) begin
            b1 = rnd_blk();
            run_block(b1, 1'b0, '0);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
